ifetch_queue: RTL and testbench

- Parametrised instruction-fetch unit: successor to the single-register PC fetch stage.
- Decouples the synchronous program ROM from decode through a DEPTH-entry prefetch queue.
- Supports one-cycle-per-instruction streaming, redirect with squash of in-flight and queued words, and a hold mode that injects NOPs (ecall lock).
- Sits between the program ROM (external, 1-cycle read latency) and the decode stage.

---
 rtl/ifetch_queue_if.sv | 28 ++
 rtl/ifetch_queue.sv | 102 ++++++++++
 tb/tb_ifetch_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: the ROM read port toward program memory and the
// instruction port toward decode, plus the execute-side redirect/hold controls.
interface ifetch_queue_if #(
    parameter int XLEN       = 32,
    parameter int ROM_ADDR_W = 14
);
    logic                  rom_en;
    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [XLEN-1:0]       rom_data;
    logic                  redirect;
    logic [XLEN-1:0]       redirect_pc;
    logic                  hold;
    logic                  inst_ready;
    logic                  inst_valid;
    logic [XLEN-1:0]       inst;
    logic [XLEN-1:0]       inst_pc;
    logic                  misalign;

    modport master (
        output rom_en, rom_addr, inst_valid, inst, inst_pc, misalign,
        input  rom_data, redirect, redirect_pc, hold, inst_ready
    );

    modport slave (
        input  rom_en, rom_addr, inst_valid, inst, inst_pc, misalign,
        output rom_data, redirect, redirect_pc, hold, inst_ready
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch with a DEPTH-entry prefetch queue between a 1-cycle-latency
// program ROM and decode; supports redirect/squash and NOP-injecting hold.
module ifetch_queue #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 4,
    parameter int              ROM_ADDR_W = 14,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter logic [XLEN-1:0] NOP_INST   = 32'h0000_0013
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master bus
);
    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] issue_pc_q, issue_pc_d;
    logic            inflight_q, inflight_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] mem_inst_q [DEPTH];
    logic [XLEN-1:0] mem_pc_q   [DEPTH];

    logic            empty;
    logic            issue;
    logic            wr_en;
    logic            deq;
    logic [CW-1:0]   occupancy;

    // Queued plus in-flight words bound issue so a returning word always has a slot.
    assign empty     = (count_q == '0);
    assign occupancy = count_q + CW'(inflight_q);
    assign issue     = rst && !bus.redirect && (occupancy < DEPTH_C);
    assign wr_en     = inflight_q && !bus.redirect;
    assign deq       = !empty && bus.inst_ready && !bus.hold && !bus.redirect;

    always_comb begin
        fpc_d      = fpc_q;
        issue_pc_d = issue_pc_q;
        inflight_d = issue;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        misalign_d = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);

        if (bus.redirect) begin
            fpc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (issue) begin
                fpc_d      = fpc_q + XLEN'(4);
                issue_pc_d = fpc_q;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(wr_en) - CW'(deq);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fpc_q      <= RESET_PC;
            issue_pc_q <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            fpc_q      <= fpc_d;
            issue_pc_q <= issue_pc_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem_inst_q[wr_ptr_q] <= bus.rom_data;
            mem_pc_q[wr_ptr_q]   <= issue_pc_q;
        end
    end

    assign bus.rom_en     = issue;
    assign bus.rom_addr   = fpc_q[ROM_ADDR_W+1:2];
    assign bus.inst_valid = !empty;
    assign bus.inst       = (bus.hold || empty) ? NOP_INST : mem_inst_q[rd_ptr_q];
    assign bus.inst_pc    = empty ? '0 : mem_pc_q[rd_ptr_q];
    assign bus.misalign   = misalign_q;
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: ROM model returns word i*0x10+0x13 one
// cycle after each strobe; head PC/word/valid checked cycle by cycle.
module tb_ifetch_queue;
    localparam int          XLEN       = 32;
    localparam int          DEPTH      = 4;
    localparam int          ROM_ADDR_W = 14;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    ifetch_queue_if #(.XLEN(XLEN), .ROM_ADDR_W(ROM_ADDR_W)) bus ();

    ifetch_queue #(
        .XLEN      (XLEN),
        .DEPTH     (DEPTH),
        .ROM_ADDR_W(ROM_ADDR_W),
        .RESET_PC  (32'h0000_0000),
        .NOP_INST  (NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [ROM_ADDR_W-1:0] a);
        return {18'b0, a} * 32'h10 + 32'h13;
    endfunction

    always @(posedge clk) begin
        if (bus.rom_en) bus.rom_data <= rom_word(bus.rom_addr);
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        logic [31:0] p;
        p = pc;
        check({tag, "_valid"}, {31'b0, bus.inst_valid}, 32'd1);
        check({tag, "_pc"}, bus.inst_pc, p);
        check({tag, "_inst"}, bus.inst, rom_word(p[15:2]));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst             = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.hold        = 1'b0;
        bus.inst_ready  = 1'b1;
        step(3);
        check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, NOP);
        check("rst_pc", bus.inst_pc, 32'd0);
        check("rst_rom_en", {31'b0, bus.rom_en}, 32'd0);
        check("rst_misalign", {31'b0, bus.misalign}, 32'd0);

        // stream start: two-cycle latency, then one word per cycle
        rst = 1'b1;
        #1;
        check("rel_rom_en", {31'b0, bus.rom_en}, 32'd1);
        check("rel_addr0", {18'b0, bus.rom_addr}, 32'd0);
        step();
        check("lat1_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("lat1_addr", {18'b0, bus.rom_addr}, 32'd1);
        step();
        check_head("first", 32'h0);
        check("addr2", {18'b0, bus.rom_addr}, 32'd2);
        step();
        check_head("second", 32'h4);

        // stall until full, then drain back-to-back
        bus.inst_ready = 1'b0;
        step(8);
        check("full_rom_en", {31'b0, bus.rom_en}, 32'd0);
        check_head("stall_head", 32'h4);
        bus.inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_head("drain", 32'h4 + 32'(4 * k));
            step();
        end

        // fill three entries plus one in flight, then redirect over them
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        #1;
        check("redir_rom_en", {31'b0, bus.rom_en}, 32'd0);
        step();
        bus.redirect = 1'b0;
        check("redir_flush", {31'b0, bus.inst_valid}, 32'd0);
        step(4);
        check_head("q3_head", 32'h40);
        check("q3_rom_en", {31'b0, bus.rom_en}, 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect   = 1'b0;
        bus.inst_ready = 1'b1;
        check("r100_c0", {31'b0, bus.inst_valid}, 32'd0);
        check("r100_misalign", {31'b0, bus.misalign}, 32'd0);
        step();
        check("r100_c1", {31'b0, bus.inst_valid}, 32'd0);
        step();
        check_head("r100_first", 32'h100);
        step();
        check_head("r100_next", 32'h104);

        // misaligned target
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h102;
        step();
        bus.redirect = 1'b0;
        check("mis_pulse", {31'b0, bus.misalign}, 32'd1);
        step();
        check("mis_clear", {31'b0, bus.misalign}, 32'd0);
        step();
        check_head("mis_target", 32'h100);

        // hold with head at 0x20
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h20;
        step();
        bus.redirect = 1'b0;
        step(2);
        check_head("hold_pre", 32'h20);
        bus.hold = 1'b1;
        #1;
        check("hold_nop", bus.inst, NOP);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_inst", bus.inst, NOP);
            check("hold_pc", bus.inst_pc, 32'h20);
            check("hold_valid", {31'b0, bus.inst_valid}, 32'd1);
        end
        check("hold_full", {31'b0, bus.rom_en}, 32'd0);
        bus.hold = 1'b0;
        #1;
        check_head("hold_rel", 32'h20);
        step();
        check_head("hold_next", 32'h24);

        // PC wrap, then reset while three queued and one in flight
        bus.inst_ready  = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        step();
        bus.redirect = 1'b0;
        step();
        check("wrap_addr_hi", {18'b0, bus.rom_addr}, 32'h3FFF);
        step();
        check("wrap_addr_lo", {18'b0, bus.rom_addr}, 32'h0);
        step(2);
        check_head("pre_rst_head", 32'hFFFF_FFF8);
        rst = 1'b0;
        step();
        check("mid_rst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check("mid_rst_pc", bus.inst_pc, 32'd0);
        check("mid_rst_inst", bus.inst, NOP);
        rst            = 1'b1;
        bus.inst_ready = 1'b1;
        #1;
        check("restart_addr", {18'b0, bus.rom_addr}, 32'd0);
        check("restart_en", {31'b0, bus.rom_en}, 32'd1);
        step();
        check("restart_lat", {31'b0, bus.inst_valid}, 32'd0);
        step();
        check_head("restart_first", 32'h0);
        step();
        check_head("restart_second", 32'h4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
